uart_receive: RTL

UART_RECEIVE -- requirements
Module: uart_receive

---
 rtl/uart_pkg.sv | 38 +++
 rtl/uart_baud_tick.sv | 44 ++++
 rtl/uart_receive.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, default rates and
// rate/counter helpers for the receiver, tick gen and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_state_e;

  localparam int DEF_CLK_HZ     = 100_000_000;
  localparam int DEF_BAUD_RT    = 115200;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Integer division; never below 1 so a tick always exists.
  function automatic int calc_tick_div(
    input int clk_hz,
    input int baud_rt,
    input int oversample
  );
    int div;
    div = clk_hz / (baud_rt * oversample);
    return (div < 1) ? 1 : div;
  endfunction

  // Counter width for a terminal value, at least one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

  localparam int DEF_TICK_DIV =
    calc_tick_div(DEF_CLK_HZ, DEF_BAUD_RT, DEF_OVERSAMPLE);
  localparam int DEF_BIT_CW = cnt_width(DEF_DATA_BITS);

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick, one pulse per TICK_DIV clocks.
// Ports: clk, reset (async active-low), tick (registered one-cycle pulse).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD_RT    = DEF_BAUD_RT,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TICK_DIV =
    calc_tick_div(CLK_HZ, BAUD_RT, OVERSAMPLE);
  localparam int CW = cnt_width(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_receive.sv
// uart_receive: oversampling UART receiver, LSB first, one stop bit.
// Ports: clk, reset (async low), rx_serial, rx_ack in; rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy out.
module uart_receive
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BAUD_RT    = DEF_BAUD_RT,
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int TW = cnt_width(OVERSAMPLE);
  localparam int BW = cnt_width(DATA_BITS);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic sync1_q, sync2_q;
  logic rx_s;
  logic tick;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_serial;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  uart_baud_tick #(
    .CLK_HZ     (CLK_HZ),
    .BAUD_RT    (BAUD_RT),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    // An ack only counts against a held byte; a good stop
    // in the same cycle re-arms rx_valid below.
    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == HALF_LAST) begin
            tcnt_d  = '0;
            bcnt_d  = '0;
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BIT_LAST) begin
              bcnt_d  = '0;
              state_d = ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              if (valid_q && !rx_ack) begin
                ovr_d = 1'b1;
              end
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_WAIT_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = busy_q;

endmodule
